// File: rtl/fsm_3.sv
// fsm_3: Moore-type overlapping detector for the serial bit pattern "101".
// One bit of `in` is consumed per sys_clk rising edge; `out` is high for
// exactly the cycles in which the registered state is S3 ("101 seen").
module fsm_3 (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic in,
    output logic out
);

    // Fixed binary encoding; S3 is the only detect state.
    typedef enum logic [1:0] {
        S0 = 2'b00,  // no useful prefix
        S1 = 2'b01,  // seen "1"
        S2 = 2'b10,  // seen "10"
        S3 = 2'b11   // seen "101"
    } state_t;

    state_t cstate;
    state_t nstate;

    // State register: reset discards any partial match, otherwise advance.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cstate <= S0;
        end else begin
            cstate <= nstate;
        end
    end

    // Next-state function; S3 falls back to S1/S2 so the trailing "1" or
    // "10" of a match can start the next one (overlapping detection).
    always_comb begin
        nstate = S0;
        case (cstate)
            S0:      nstate = in ? S1 : S0;
            S1:      nstate = in ? S1 : S2;
            S2:      nstate = in ? S3 : S0;
            S3:      nstate = in ? S1 : S2;
            default: nstate = S0;
        endcase
    end

    // Moore output: depends on the registered state only, never on `in`.
    assign out = (cstate == S3);

endmodule

// File: tb/tb_fsm_3.sv
// tb_fsm_3: directed-vector bench for fsm_3 with a history-based reference
// model (the detector state is derived from the last bits seen since reset).
module tb_fsm_3;

    logic sys_clk;
    logic sys_rst;
    logic in;
    logic out;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: last three bits since reset and how many are valid.
    logic [2:0] hist    = 3'b000;
    int         hcount  = 0;
    bit         started = 0;

    fsm_3 dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .in      (in),
        .out     (out)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Which prefix of "101" does the recent history end in?
    function automatic logic [1:0] state_of(input logic [2:0] h, input int c);
        if (c >= 3 && h == 3'b101)      return 2'd3;
        else if (c >= 2 && h[1:0] == 2'b10) return 2'd2;
        else if (c >= 1 && h[0])        return 2'd1;
        else                            return 2'd0;
    endfunction

    function automatic logic [1:0] model_state();
        return state_of(hist, hcount);
    endfunction

    function automatic logic [1:0] model_next(input logic b);
        return state_of({hist[1:0], b}, (hcount >= 3) ? 3 : hcount + 1);
    endfunction

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Model update on the same edge the DUT samples.
    always @(posedge sys_clk) begin
        if (sys_rst) begin
            hist   <= 3'b000;
            hcount <= 0;
        end else begin
            hist   <= {hist[1:0], in};
            hcount <= (hcount >= 3) ? 3 : hcount + 1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge sys_clk) begin
        if (started) begin
            check("model_cstate", dut.cstate, model_state());
            check("model_out",    {1'b0, out}, {1'b0, model_state() == 2'd3});
            check("model_nstate", dut.nstate, model_next(in));
        end
    end

    // Apply one edge, then pin DUT and model against a hand-computed state.
    task automatic step(input logic r, input logic b, input logic [1:0] exp_st);
        sys_rst = r;
        in      = b;
        @(posedge sys_clk);
        #1;
        started = 1;
        check("lit_cstate", dut.cstate, exp_st);
        check("lit_out",    {1'b0, out}, {1'b0, exp_st == 2'd3});
        check("lit_model",  model_state(), exp_st);
    endtask

    typedef struct {
        logic       b;
        logic [1:0] st;
    } vec_t;

    vec_t main_v[8]    = '{'{0,0},'{1,1},'{0,2},'{1,3},'{0,2},'{1,3},'{1,1},'{0,2}};
    vec_t nomatch_v[9] = '{'{1,1},'{1,1},'{1,1},'{0,2},'{0,0},'{1,1},'{1,1},'{0,2},'{0,0}};
    vec_t overlap_v[7] = '{'{1,1},'{0,2},'{1,3},'{0,2},'{1,3},'{0,2},'{1,3}};

    initial begin
        sys_rst = 1'b1;
        in      = 1'b0;

        // Reset with `in` toggling
        step(1, 0, 2'd0);
        step(1, 1, 2'd0);

        // Main stream: detections after bits 4 and 6
        foreach (main_v[i]) step(0, main_v[i].b, main_v[i].st);

        // No-match stream
        step(1, 0, 2'd0);
        foreach (nomatch_v[i]) step(0, nomatch_v[i].b, nomatch_v[i].st);

        // Overlap chain: pulses after bits 3, 5, 7
        step(1, 0, 2'd0);
        foreach (overlap_v[i]) step(0, overlap_v[i].b, overlap_v[i].st);

        // Reset while in S3 drops out
        step(1, 1, 2'd0);

        // Mid-sequence reset discards "10"
        step(0, 1, 2'd1);
        step(0, 0, 2'd2);
        step(1, 1, 2'd0);
        step(0, 1, 2'd1);
        step(0, 0, 2'd2);
        step(0, 1, 2'd3);

        // Combinational next state while holding S2
        step(1, 0, 2'd0);
        step(0, 1, 2'd1);
        step(0, 0, 2'd2);
        in = 1'b1;
        #1;
        check("comb_nstate_in1", dut.nstate, 2'd3);
        check("comb_out_hold",   {1'b0, out}, 2'd0);
        in = 1'b0;
        #1;
        check("comb_nstate_in0", dut.nstate, 2'd0);
        check("comb_cstate_hold", dut.cstate, 2'd2);
        in = 1'b1;
        #1;
        check("comb_nstate_back", dut.nstate, 2'd3);
        check("comb_out_still0", {1'b0, out}, 2'd0);
        step(0, 1, 2'd3);

        @(negedge sys_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
